// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  // Controller states: waiting, shifting bits through the cell, result just registered.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sub_state_t;

  // Bit counter width; one spare bit so the count can never wrap inside a run.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/one_bit_full_subtractor.sv
// Single full-subtractor cell: d = x - y - bin, with borrow out.
module one_bit_full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference is the three-way XOR; borrow when y (plus incoming borrow) exceeds x.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// A start/done handshake frames each operation; result registers hold between completions.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned    CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  sub_state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;

  logic bit_d;
  logic bit_bout;

  // The one shared cell always sees the current LSBs and the running borrow.
  one_bit_full_subtractor u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Handshake outputs decoded from the current state.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      S_IDLE: ready = 1'b1;
      S_RUN:  busy  = 1'b1;
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Next-state and datapath updates: load on accepted start, shift one bit per RUN cycle.
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    d_sh_d     = d_sh_q;
    br_d       = br_q;
    cnt_d      = cnt_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          d_sh_d  = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        d_sh_d = {bit_d, d_sh_q[WIDTH-1:1]};
        br_d   = bit_bout;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d  = S_DONE;
          diff_d   = d_sh_d;
          borrow_d = bit_bout;
          // On the last bit the shifters' LSBs are the captured operand MSBs.
          overflow_d = (a_sh_q[0] ^ b_sh_q[0]) & (bit_d ^ a_sh_q[0]);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any run in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift registers, bit counter, borrow flop and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      d_sh_q     <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      d_sh_q     <= d_sh_d;
      br_q       <= br_d;
      cnt_q      <= cnt_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: plain modular arithmetic and the signed-overflow rule.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.diff     = av - bv;
    e.borrow   = (av < bv);
    e.overflow = (av[W-1] != bv[W-1]) && (e.diff[W-1] != av[W-1]);
    return e;
  endfunction

  // Drive one accepted start and record the expected result.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    sb.push_back(model(av, bv));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, giving up after 20.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if ({diff, borrow, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_result: got %b/%b/%b want 0/0/0", diff, borrow, overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int   n;
    int   busy_cycles;
    exp_t e;
    issue(4'd5, 4'd3);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL run_ready: got %b want 0", ready); end
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_cycles++;
    end
    checks++;
    if (n != W) begin errors++; $display("FAIL basic_latency: got %0d want %0d", n + 1, W + 1); end
    checks++;
    if (busy_cycles != W) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d want %0d", busy_cycles, W);
    end
    e = sb.pop_front();
    checks++;
    if ({diff, borrow, overflow} !== e || diff !== 4'd2) begin
      errors++;
      $display("FAIL basic_5_3: got %h/%b/%b want %h/%b/%b", diff, borrow, overflow,
               e.diff, e.borrow, e.overflow);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width: got done=%b ready=%b busy=%b want 0/1/0", done, ready, busy);
    end

    issue(4'd3, 4'd5);
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != W || {diff, borrow, overflow} !== e || diff !== 4'b1110) begin
      errors++;
      $display("FAIL basic_3_5: got %h/%b/%b lat %0d want %h/%b/%b lat %0d", diff, borrow,
               overflow, n + 1, e.diff, e.borrow, e.overflow, W + 1);
    end
  endtask

  task automatic test_overflow();
    int   n;
    exp_t e;
    issue(4'b0111, 4'b1111);
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != W || {diff, borrow, overflow} !== {4'b1000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ovf_7_m1: got %b/%b/%b lat %0d want 1000/1/1 lat %0d", diff, borrow,
               overflow, n + 1, W + 1);
    end
    issue(4'b1000, 4'b0001);
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != W || {diff, borrow, overflow} !== e) begin
      errors++;
      $display("FAIL ovf_m8_1: got %b/%b/%b want %b/%b/%b", diff, borrow, overflow,
               e.diff, e.borrow, e.overflow);
    end
  endtask

  task automatic test_ignore_start();
    int   n;
    int   extra;
    exp_t e;
    issue(4'd9, 4'd4);
    a     = 4'd0;
    b     = 4'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != W - 1 || {diff, borrow, overflow} !== e || diff !== 4'd5) begin
      errors++;
      $display("FAIL ignore_start: got %h/%b/%b want %h/%b/%b", diff, borrow, overflow,
               e.diff, e.borrow, e.overflow);
    end
    extra = 0;
    for (int i = 0; i < 2 * W + 2; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_not_queued: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    a     = 4'd7;
    b     = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || diff !== 4'd0) begin
      errors++;
      $display("FAIL midrun_reset: got ready=%b busy=%b done=%b diff=%h want 1/0/0/0", ready,
               busy, done, diff);
    end
    pulses = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midrun_no_done: got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int   n;
    exp_t e;
    a     = 4'd10;
    b     = 4'd3;
    start = 1'b1;
    sb.push_back(model(4'd10, 4'd3));
    @(posedge clk);
    #1;
    a = 4'd6;
    b = 4'd6;
    sb.push_back(model(4'd6, 4'd6));
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != W || ready !== 1'b1 || {diff, borrow, overflow} !== e) begin
      errors++;
      $display("FAIL b2b_first: got %h/%b/%b ready=%b want %h/%b/%b ready=1", diff, borrow,
               overflow, ready, e.diff, e.borrow, e.overflow);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || diff !== 4'd7) begin
      errors++;
      $display("FAIL b2b_reload: got busy=%b done=%b diff=%h want 1/0/7", busy, done, diff);
    end
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != W || {diff, borrow, overflow} !== e || diff !== 4'd0) begin
      errors++;
      $display("FAIL b2b_second: got %h/%b/%b want %h/%b/%b", diff, borrow, overflow,
               e.diff, e.borrow, e.overflow);
    end
  endtask

  task automatic test_sweep();
    int           n;
    exp_t         e;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        av = ai[W-1:0];
        bv = bi[W-1:0];
        issue(av, bv);
        wait_done(n);
        e = sb.pop_front();
        checks++;
        if (n != W || {diff, borrow, overflow} !== e) begin
          errors++;
          $display("FAIL sweep %0d-%0d: got %h/%b/%b lat %0d want %h/%b/%b lat %0d", ai, bi,
                   diff, borrow, overflow, n + 1, e.diff, e.borrow, e.overflow, W + 1);
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
